// File: rtl/synth_poly_if.sv
// synth_poly_if
// Groups the keypad/control inputs and the audio/status outputs of synth_poly.
//   en        : global enable
//   NOTES     : 13 key levels, bit 0 = C4 .. bit 12 = C5
//   MODE      : waveform-select button level
//   OCTAVE    : octave-toggle button level
//   pwm_o     : PWM audio output
//   mode_o    : current waveform (0 square, 1 saw, 2 triangle, 3 noise)
//   octave_o  : 1 = one octave up
//   active_o  : bit k = voice k holds a note
// master drives the inputs (keypad side), slave is the synth core.
interface synth_poly_if #(
    parameter int VOICES = 4
);
    logic              en;
    logic [12:0]       NOTES;
    logic              MODE;
    logic              OCTAVE;
    logic              pwm_o;
    logic [1:0]        mode_o;
    logic              octave_o;
    logic [VOICES-1:0] active_o;

    modport master (
        output en, NOTES, MODE, OCTAVE,
        input  pwm_o, mode_o, octave_o, active_o
    );

    modport slave (
        input  en, NOTES, MODE, OCTAVE,
        output pwm_o, mode_o, octave_o, active_o
    );
endinterface

// File: rtl/synth_poly.sv
// synth_poly
// Polyphonic keypad synthesizer. Up to VOICES pressed keys (C4..C5) are packed
// lowest-key-first onto phase-accumulator oscillators, shaped as square, saw or
// triangle, averaged, and played out through a single PWM pin.
// Ports:
//   clk : 10 MHz system clock, rising edge
//   RST : synchronous active-high reset
//   bus : synth_poly_if.slave (en, NOTES, MODE, OCTAVE in; pwm_o, mode_o,
//         octave_o, active_o out)
// Optional build macro SYNTH_POLY_NOISE_EN adds a NOISE waveform driven by a
// 16-bit LFSR clocked from voice 0's phase.
//
// state      | meaning
// ST_SQUARE  | square wave (reset state)
// ST_SAW     | sawtooth
// ST_TRI     | triangle
// ST_NOISE   | LFSR noise (SYNTH_POLY_NOISE_EN builds only)
module synth_poly #(
    parameter int VOICES  = 4,
    parameter int PWM_W   = 8,
    parameter int PHASE_W = 24
) (
    input  logic        clk,
    input  logic        RST,
    synth_poly_if.slave bus
);
    localparam int LOG2V = $clog2(VOICES);
    localparam int SUM_W = PWM_W + LOG2V;

    localparam logic [1:0] ST_SQUARE = 2'd0;
    localparam logic [1:0] ST_SAW    = 2'd1;
    localparam logic [1:0] ST_TRI    = 2'd2;
`ifdef SYNTH_POLY_NOISE_EN
    localparam logic [1:0] ST_NOISE  = 2'd3;
`endif

    logic [12:0]        notes_r;
    logic               mode_r, mode_d, oct_r, oct_d, en_r;
    logic [1:0]         state;
    logic               octave;
    logic [3:0]         note_idx  [VOICES];
    logic [VOICES-1:0]  active;
    logic [PHASE_W-1:0] phase     [VOICES];
    logic [3:0]         alloc_idx [VOICES];
    logic [VOICES-1:0]  alloc_act;
    logic [PHASE_W-1:0] inc       [VOICES];
    logic [PWM_W-1:0]   sample    [VOICES];
    logic [PWM_W:0]     p;
    logic [SUM_W-1:0]   sum;
    logic [PWM_W-1:0]   mix, duty, cnt;
    logic               pwm;
    int                 seen;

`ifdef SYNTH_POLY_NOISE_EN
    logic [15:0]        lfsr;
    logic               msb0_d;
`endif

    // Equal-tempered tuning words, round(f * 2^24 / 10 MHz).
    function automatic logic [PHASE_W-1:0] tune(input logic [3:0] idx);
        logic [9:0] w;
        case (idx)
            4'd0:    w = 10'd439;
            4'd1:    w = 10'd465;
            4'd2:    w = 10'd493;
            4'd3:    w = 10'd522;
            4'd4:    w = 10'd553;
            4'd5:    w = 10'd586;
            4'd6:    w = 10'd621;
            4'd7:    w = 10'd658;
            4'd8:    w = 10'd697;
            4'd9:    w = 10'd738;
            4'd10:   w = 10'd782;
            4'd11:   w = 10'd829;
            4'd12:   w = 10'd878;
            default: w = 10'd0;
        endcase
        return PHASE_W'(w);
    endfunction

    // Input register plus a second stage for button edge detection.
    always_ff @(posedge clk) begin
        if (RST) begin
            notes_r <= '0;
            mode_r  <= 1'b0;
            mode_d  <= 1'b0;
            oct_r   <= 1'b0;
            oct_d   <= 1'b0;
            en_r    <= 1'b0;
        end else begin
            notes_r <= bus.NOTES;
            mode_r  <= bus.MODE;
            mode_d  <= mode_r;
            oct_r   <= bus.OCTAVE;
            oct_d   <= oct_r;
            en_r    <= bus.en;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state  <= ST_SQUARE;
            octave <= 1'b0;
        end else begin
            if (mode_r && !mode_d) begin
                case (state)
                    ST_SQUARE: state <= ST_SAW;
                    ST_SAW:    state <= ST_TRI;
`ifdef SYNTH_POLY_NOISE_EN
                    ST_TRI:    state <= ST_NOISE;
`endif
                    default:   state <= ST_SQUARE;
                endcase
            end
            if (oct_r && !oct_d)
                octave <= ~octave;
        end
    end

    // Voice k takes the k-th lowest pressed key; keys past VOICES fall off.
    always_comb begin
        alloc_act = '0;
        seen      = 0;
        for (int k = 0; k < VOICES; k++) begin
            alloc_idx[k] = '0;
            seen         = 0;
            for (int i = 0; i < 13; i++) begin
                if (notes_r[i]) begin
                    if (seen == k) begin
                        alloc_idx[k] = 4'(i);
                        alloc_act[k] = 1'b1;
                    end
                    seen = seen + 1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < VOICES; k++)
            inc[k] = octave ? (tune(note_idx[k]) << 1) : tune(note_idx[k]);
    end

    // A voice whose note index is being replaced restarts from phase 0 so a
    // re-packed voice never continues the previous key's waveform.
    always_ff @(posedge clk) begin
        if (RST) begin
            active <= '0;
            for (int k = 0; k < VOICES; k++) begin
                note_idx[k] <= '0;
                phase[k]    <= '0;
            end
        end else begin
            active <= alloc_act;
            for (int k = 0; k < VOICES; k++) begin
                note_idx[k] <= alloc_idx[k];
                if (!bus.en || !active[k] || (alloc_idx[k] != note_idx[k]))
                    phase[k] <= '0;
                else
                    phase[k] <= phase[k] + inc[k];
            end
        end
    end

`ifdef SYNTH_POLY_NOISE_EN
    // Fibonacci LFSR, taps 16/14/13/11, stepped once per voice-0 cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            lfsr   <= 16'hACE1;
            msb0_d <= 1'b0;
        end else begin
            msb0_d <= phase[0][PHASE_W-1];
            if (state == ST_NOISE && phase[0][PHASE_W-1] && !msb0_d)
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`endif

    always_comb begin
        sum = '0;
        p   = '0;
        for (int k = 0; k < VOICES; k++) begin
            sample[k] = '0;
            p         = phase[k][PHASE_W-1 -: PWM_W+1];
            if (active[k]) begin
                case (state)
                    ST_SQUARE: sample[k] = p[PWM_W] ? '0 : '1;
                    ST_SAW:    sample[k] = p[PWM_W:1];
                    ST_TRI:    sample[k] = p[PWM_W] ? ~p[PWM_W-1:0] : p[PWM_W-1:0];
`ifdef SYNTH_POLY_NOISE_EN
                    ST_NOISE:  sample[k] = lfsr[PWM_W-1:0];
`endif
                    default:   sample[k] = '0;
                endcase
            end
            sum = sum + SUM_W'(sample[k]);
        end
    end

    // Mix is gated by the registered enable so it drops one cycle after the
    // phases have already been cleared.
    always_ff @(posedge clk) begin
        if (RST) begin
            mix  <= '0;
            cnt  <= '0;
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            mix <= en_r ? PWM_W'(sum >> LOG2V) : '0;
            cnt <= cnt + 1'b1;
            if (cnt == '1)
                duty <= mix;
            pwm <= (cnt < duty);
        end
    end

    assign bus.pwm_o    = pwm;
    assign bus.mode_o   = state;
    assign bus.octave_o = octave;
    assign bus.active_o = active;
endmodule

// File: tb/tb_synth_poly.sv
// tb_synth_poly
// Self-checking bench for synth_poly (VOICES=4, PWM_W=8, PHASE_W=24).
// Expected values are pushed to exp_q when stimulus is applied and popped
// when the corresponding DUT response is sampled on the falling clock edge.
module tb_synth_poly;
    logic tb_clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    synth_poly_if #(.VOICES(4)) bus_if ();

    synth_poly #(.VOICES(4), .PWM_W(8), .PHASE_W(24)) dut (
        .clk (tb_clk),
        .RST (rst),
        .bus (bus_if)
    );

    task automatic step(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic pulse_mode();
        bus_if.MODE = 1'b1;
        @(negedge tb_clk);
        bus_if.MODE = 1'b0;
    endtask

    task automatic pulse_octave();
        bus_if.OCTAVE = 1'b1;
        @(negedge tb_clk);
        bus_if.OCTAVE = 1'b0;
    endtask

    // Waits for mix to step up to the single-voice square level (63).
    task automatic wait_mix_rise(input int budget, output int t, output bit ok);
        logic [7:0] prev;
        prev = dut.mix;
        ok   = 1'b0;
        t    = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge tb_clk);
            if (dut.mix == 8'd63 && prev != 8'd63) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
            prev = dut.mix;
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst = 1'b1;
        step(2);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.pwm_o !== e[0]) $display("FAIL reset_pwm: got %0b expected %0b", bus_if.pwm_o, e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.mode_o !== e[1:0]) $display("FAIL reset_mode: got %0d expected %0d", bus_if.mode_o, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.octave_o !== e[0]) $display("FAIL reset_octave: got %0b expected %0b", bus_if.octave_o, e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.active_o !== e[3:0]) $display("FAIL reset_active: got %0h expected %0h", bus_if.active_o, e[3:0]); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(0);
            step(1);
            e = exp_q.pop_front(); n_checks++;
            if ({bus_if.pwm_o, bus_if.mode_o, bus_if.octave_o, bus_if.active_o} !== e[7:0])
                $display("FAIL reset_hold: cycle %0d got %0h expected %0h", i,
                         {bus_if.pwm_o, bus_if.mode_o, bus_if.octave_o, bus_if.active_o}, e[7:0]);
            else n_pass++;
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_single_square();
        logic [31:0] e;
        int t0, t1, per, highs;
        bit ok, found;
        bus_if.en    = 1'b1;
        bus_if.NOTES = 13'h0001;
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        step(2);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.active_o !== e[3:0]) $display("FAIL square_active: got %0h expected %0h", bus_if.active_o, e[3:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.phase[0] !== e[23:0]) $display("FAIL square_phase_start: got %0d expected %0d", dut.phase[0], e[23:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.mix !== e[7:0]) $display("FAIL square_mix_before: got %0d expected %0d", dut.mix, e[7:0]); else n_pass++;
        exp_q.push_back(439); exp_q.push_back(63);
        step(1);
        t0 = cyc;
        e = exp_q.pop_front(); n_checks++;
        if (dut.phase[0] !== e[23:0]) $display("FAIL square_phase_first_inc: got %0d expected %0d", dut.phase[0], e[23:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.mix !== e[7:0]) $display("FAIL square_mix_high: got %0d expected %0d", dut.mix, e[7:0]); else n_pass++;

        exp_q.push_back(63);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(1);
            if (dut.cnt == 8'd0 && dut.duty == 8'd63) found = 1'b1;
        end
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (bus_if.pwm_o === 1'b1) highs++;
        end
        e = exp_q.pop_front(); n_checks++;
        if (!found || highs != int'(e)) $display("FAIL square_pwm_highs: got %0d (frame found %0b) expected %0d", highs, found, e);
        else n_pass++;

        exp_q.push_back(38216);
        wait_mix_rise(40000, t1, ok);
        per = t1 - t0;
        e = exp_q.pop_front(); n_checks++;
        if (!ok || per < int'(e) - 1 || per > int'(e) + 1)
            $display("FAIL square_period: got %0d (seen %0b) expected %0d+-1", per, ok, e);
        else n_pass++;
        bus_if.NOTES = '0;
        step(4);
    endtask

    task automatic test_polyphony();
        logic [31:0] e;
        bus_if.NOTES = 13'h001F;
        exp_q.push_back(4'hF); exp_q.push_back(3);
        step(3);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.active_o !== e[3:0]) $display("FAIL poly_active: got %0h expected %0h", bus_if.active_o, e[3:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.note_idx[3] !== e[3:0]) $display("FAIL poly_voice3_note: got %0d expected %0d", dut.note_idx[3], e[3:0]); else n_pass++;
        step(20);
        bus_if.NOTES = 13'h001E;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(4'hF);
        step(2);
        e = exp_q.pop_front(); n_checks++;
        if (dut.phase[0] !== e[23:0]) $display("FAIL repack_phase_clear: got %0d expected %0d", dut.phase[0], e[23:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.note_idx[0] !== e[3:0]) $display("FAIL repack_voice0_note: got %0d expected %0d", dut.note_idx[0], e[3:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.active_o !== e[3:0]) $display("FAIL repack_active: got %0h expected %0h", bus_if.active_o, e[3:0]); else n_pass++;
        exp_q.push_back(465); exp_q.push_back(4);
        step(1);
        e = exp_q.pop_front(); n_checks++;
        if (dut.phase[0] !== e[23:0]) $display("FAIL repack_phase_restart: got %0d expected %0d", dut.phase[0], e[23:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.note_idx[3] !== e[3:0]) $display("FAIL repack_voice3_note: got %0d expected %0d", dut.note_idx[3], e[3:0]); else n_pass++;
        bus_if.NOTES = '0;
        step(4);
    endtask

    task automatic test_mode_octave();
        logic [31:0] e;
        logic [23:0] ph;
        logic [8:0]  p;
        logic [7:0]  s;
        int t0, t1, per;
        bit ok0, ok1;
        int k;

        exp_q.push_back(1);
        pulse_octave();
        step(4);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.octave_o !== e[0]) $display("FAIL octave_toggle: got %0b expected %0b", bus_if.octave_o, e[0]); else n_pass++;

        exp_q.push_back(1);
        pulse_mode();
        step(4);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.mode_o !== e[1:0]) $display("FAIL mode_step1: got %0d expected %0d", bus_if.mode_o, e[1:0]); else n_pass++;

        k  = 3000;
        ph = 24'(k * 1756);
        p  = ph[23:15];
        s  = p[8:1];
        exp_q.push_back(32'(s >> 2));
        bus_if.NOTES = 13'h1000;
        step(3 + k);
        e = exp_q.pop_front(); n_checks++;
        if (dut.mix !== e[7:0]) $display("FAIL saw_mix: got %0d expected %0d", dut.mix, e[7:0]); else n_pass++;
        bus_if.NOTES = '0;
        step(4);

        exp_q.push_back(2);
        pulse_mode();
        step(4);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.mode_o !== e[1:0]) $display("FAIL mode_step2: got %0d expected %0d", bus_if.mode_o, e[1:0]); else n_pass++;

        k  = 6000;
        ph = 24'(k * 1756);
        p  = ph[23:15];
        s  = p[8] ? ~p[7:0] : p[7:0];
        exp_q.push_back(32'(s >> 2));
        bus_if.NOTES = 13'h1000;
        step(3 + k);
        e = exp_q.pop_front(); n_checks++;
        if (dut.mix !== e[7:0]) $display("FAIL tri_mix: got %0d expected %0d", dut.mix, e[7:0]); else n_pass++;
        bus_if.NOTES = '0;
        step(4);

`ifdef SYNTH_POLY_NOISE_EN
        exp_q.push_back(3);
`else
        exp_q.push_back(0);
`endif
        pulse_mode();
        step(4);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.mode_o !== e[1:0]) $display("FAIL mode_step3: got %0d expected %0d", bus_if.mode_o, e[1:0]); else n_pass++;
`ifdef SYNTH_POLY_NOISE_EN
        exp_q.push_back(0);
        pulse_mode();
        step(4);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.mode_o !== e[1:0]) $display("FAIL mode_step4: got %0d expected %0d", bus_if.mode_o, e[1:0]); else n_pass++;
`endif

        exp_q.push_back(9554);
        bus_if.NOTES = 13'h1000;
        wait_mix_rise(20, t0, ok0);
        wait_mix_rise(12000, t1, ok1);
        per = t1 - t0;
        e = exp_q.pop_front(); n_checks++;
        if (!ok0 || !ok1 || per < int'(e) - 1 || per > int'(e) + 1)
            $display("FAIL octave_period: got %0d (seen %0b%0b) expected %0d+-1", per, ok0, ok1, e);
        else n_pass++;
        bus_if.NOTES = '0;
        step(4);
    endtask

    task automatic test_enable_drop();
        logic [31:0] e;
        int highs;
        bus_if.NOTES = 13'h0200;
        exp_q.push_back(63);
        step(100);
        e = exp_q.pop_front(); n_checks++;
        if (dut.mix !== e[7:0]) $display("FAIL en_mix_playing: got %0d expected %0d", dut.mix, e[7:0]); else n_pass++;
        bus_if.en = 1'b0;
        exp_q.push_back(0); exp_q.push_back(0);
        step(2);
        e = exp_q.pop_front(); n_checks++;
        if (dut.mix !== e[7:0]) $display("FAIL en_mix_zero: got %0d expected %0d", dut.mix, e[7:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.phase[0] !== e[23:0]) $display("FAIL en_phase_zero: got %0d expected %0d", dut.phase[0], e[23:0]); else n_pass++;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
        step(256);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.pwm_o !== e[0]) $display("FAIL en_pwm_low: got %0b expected %0b", bus_if.pwm_o, e[0]); else n_pass++;
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (bus_if.pwm_o !== 1'b0) highs++;
        end
        e = exp_q.pop_front(); n_checks++;
        if (highs != int'(e)) $display("FAIL en_pwm_stays_low: got %0d high cycles expected %0d", highs, e); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.octave_o !== e[0]) $display("FAIL en_octave_kept: got %0b expected %0b", bus_if.octave_o, e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.mode_o !== e[1:0]) $display("FAIL en_mode_kept: got %0d expected %0d", bus_if.mode_o, e[1:0]); else n_pass++;
        bus_if.NOTES = '0;
        bus_if.en    = 1'b1;
        step(4);
    endtask

    task automatic test_reset_mid_note();
        logic [31:0] e;
        pulse_mode();
        bus_if.NOTES = 13'h1000;
        step(50);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(0);
        step(1);
        rst = 1'b0;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.pwm_o !== e[0]) $display("FAIL rst_pwm: got %0b expected %0b", bus_if.pwm_o, e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.mode_o !== e[1:0]) $display("FAIL rst_mode: got %0d expected %0d", bus_if.mode_o, e[1:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.octave_o !== e[0]) $display("FAIL rst_octave: got %0b expected %0b", bus_if.octave_o, e[0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.active_o !== e[3:0]) $display("FAIL rst_active: got %0h expected %0h", bus_if.active_o, e[3:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.mix !== e[7:0]) $display("FAIL rst_mix: got %0d expected %0d", dut.mix, e[7:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.duty !== e[7:0]) $display("FAIL rst_duty: got %0d expected %0d", dut.duty, e[7:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.cnt !== e[7:0]) $display("FAIL rst_cnt: got %0d expected %0d", dut.cnt, e[7:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.phase[0] !== e[23:0]) $display("FAIL rst_phase: got %0d expected %0d", dut.phase[0], e[23:0]); else n_pass++;

        exp_q.push_back(0);
        step(1);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.active_o !== e[3:0]) $display("FAIL resume_active_c1: got %0h expected %0h", bus_if.active_o, e[3:0]); else n_pass++;
        exp_q.push_back(1); exp_q.push_back(0);
        step(1);
        e = exp_q.pop_front(); n_checks++;
        if (bus_if.active_o !== e[3:0]) $display("FAIL resume_active_c2: got %0h expected %0h", bus_if.active_o, e[3:0]); else n_pass++;
        e = exp_q.pop_front(); n_checks++;
        if (dut.phase[0] !== e[23:0]) $display("FAIL resume_phase_c2: got %0d expected %0d", dut.phase[0], e[23:0]); else n_pass++;
        exp_q.push_back(878);
        step(1);
        e = exp_q.pop_front(); n_checks++;
        if (dut.phase[0] !== e[23:0]) $display("FAIL resume_phase_c3: got %0d expected %0d", dut.phase[0], e[23:0]); else n_pass++;
        bus_if.NOTES = '0;
        step(4);
    endtask

    initial begin
        rst           = 1'b1;
        bus_if.en     = 1'b0;
        bus_if.NOTES  = '0;
        bus_if.MODE   = 1'b0;
        bus_if.OCTAVE = 1'b0;
        test_reset();
        test_single_square();
        test_polyphony();
        test_mode_octave();
        test_enable_drop();
        test_reset_mid_note();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
